// File: rtl/puzzle_pkg.sv
// rtl/puzzle_pkg.sv - shared geometry, types and FSM states for the puzzle tile reader
package puzzle_pkg;
    localparam int DATA_W    = 5;
    localparam int ADDR_W    = 6;
    localparam int GRID_W    = 8;
    localparam int GRID_H    = 8;
    localparam int TILE_W    = 32;
    localparam int TILE_H    = 30;
    localparam int SUB_W     = 5;
    localparam int NUM_TILES = GRID_W * GRID_H;
    localparam int GX_W      = $clog2(GRID_W);
    localparam int GY_W      = $clog2(GRID_H);

    typedef logic [DATA_W-1:0] tile_code_t;
    typedef logic [ADDR_W-1:0] tile_addr_t;
    typedef logic [SUB_W-1:0]  sub_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SNAP = 2'd1,
        RUN  = 2'd2
    } rd_state_t;
endpackage

// File: rtl/puzzle_tile_reader_if.sv
// rtl/puzzle_tile_reader_if.sv - puzzle RAM read port plus tile stream to the pixel renderer
interface puzzle_tile_reader_if;
    import puzzle_pkg::*;

    logic       ram_re;
    tile_addr_t ram_raddr;
    tile_code_t ram_rdata;
    logic       tile_valid;
    tile_code_t tile_code;
    sub_t       sub_x;
    sub_t       sub_y;

    modport master (
        output ram_re,
        output ram_raddr,
        input  ram_rdata,
        output tile_valid,
        output tile_code,
        output sub_x,
        output sub_y
    );

    modport slave (
        input  ram_re,
        input  ram_raddr,
        output ram_rdata,
        input  tile_valid,
        input  tile_code,
        input  sub_x,
        input  sub_y
    );
endinterface

// File: rtl/puzzle_tile_reader_shadow_rf.sv
// rtl/puzzle_tile_reader_shadow_rf.sv - 64-entry tile code shadow, one write port, async read
module puzzle_shadow_rf
    import puzzle_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       we,
    input  tile_addr_t waddr,
    input  tile_code_t wdata,
    input  tile_addr_t raddr,
    output tile_code_t rdata
);
    tile_code_t mem [NUM_TILES];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_TILES; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/puzzle_tile_reader.sv
// rtl/puzzle_tile_reader.sv - frame-start tile snapshot and pixel-to-tile mapper
// TILE_GRID_EN: force tile_code to all ones on the first column/line of every tile.
module puzzle_tile_reader
    import puzzle_pkg::*;
(
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        frame_start,
    input  logic                        line_start,
    input  logic                        pix_valid,
    output logic                        snap_busy,
    output logic                        err_overrun,
    puzzle_tile_reader_if.master        tile_bus
);
    localparam logic [ADDR_W:0] SNAP_LAST = (ADDR_W+1)'(NUM_TILES);
    localparam sub_t            COL_LAST  = SUB_W'(TILE_W - 1);
    localparam sub_t            ROW_LAST  = SUB_W'(TILE_H - 1);
    localparam logic [GX_W-1:0] TX_LAST   = GX_W'(GRID_W - 1);
    localparam logic [GY_W-1:0] TY_LAST   = GY_W'(GRID_H - 1);

    rd_state_t       state_q, state_d;
    logic [ADDR_W:0] snap_cnt_q, snap_cnt_d;

    logic [GX_W-1:0] tile_x_q;
    logic [GY_W-1:0] tile_y_q;
    sub_t            col_q, row_q;
    logic            first_line_q;

    tile_addr_t      rd_idx;
    tile_code_t      shadow_code;
    tile_code_t      px_code;
    sub_t            px_col, px_row;
    logic            shadow_we;
    tile_addr_t      shadow_waddr;

    logic            tile_valid_q;
    tile_code_t      tile_code_q;
    sub_t            sub_x_q, sub_y_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            snap_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            snap_cnt_q <= snap_cnt_d;
        end
    end

    // Snapshot counter runs 0..64: reads issue on 0..63, the last write lands on 64.
    always_comb begin
        state_d    = state_q;
        snap_cnt_d = snap_cnt_q;
        unique case (state_q)
            IDLE, RUN: begin
                if (frame_start) begin
                    state_d    = SNAP;
                    snap_cnt_d = '0;
                end
            end
            SNAP: begin
                if (frame_start) begin
                    snap_cnt_d = '0;
                end else if (snap_cnt_q == SNAP_LAST) begin
                    state_d    = RUN;
                    snap_cnt_d = '0;
                end else begin
                    snap_cnt_d = snap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                snap_cnt_d = '0;
            end
        endcase
    end

    assign snap_busy          = (state_q == SNAP);
    assign tile_bus.ram_re    = snap_busy && !snap_cnt_q[ADDR_W];
    assign tile_bus.ram_raddr = snap_cnt_q[ADDR_W-1:0];

    // Data for the address issued last cycle; low bits of 64 minus one wrap to 63.
    assign shadow_we    = snap_busy && (snap_cnt_q != '0);
    assign shadow_waddr = snap_cnt_q[ADDR_W-1:0] - 1'b1;

    puzzle_shadow_rf u_shadow (
        .clock   (clock),
        .reset_n (reset_n),
        .we      (shadow_we),
        .waddr   (shadow_waddr),
        .wdata   (tile_bus.ram_rdata),
        .raddr   (rd_idx),
        .rdata   (shadow_code)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tile_x_q     <= '0;
            tile_y_q     <= '0;
            col_q        <= '0;
            row_q        <= '0;
            first_line_q <= 1'b0;
        end else if (frame_start) begin
            tile_x_q     <= '0;
            tile_y_q     <= '0;
            col_q        <= '0;
            row_q        <= '0;
            first_line_q <= 1'b1;
        end else if (line_start) begin
            col_q    <= '0;
            tile_x_q <= '0;
            if (first_line_q) begin
                first_line_q <= 1'b0;
            end else if (row_q == ROW_LAST) begin
                row_q <= '0;
                if (tile_y_q != TY_LAST) begin
                    tile_y_q <= tile_y_q + 1'b1;
                end
            end else begin
                row_q <= row_q + 1'b1;
            end
        end else if (pix_valid) begin
            if (col_q == COL_LAST) begin
                col_q <= '0;
                if (tile_x_q != TX_LAST) begin
                    tile_x_q <= tile_x_q + 1'b1;
                end
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    // A pixel arriving with frame_start sees the cleared counters.
    assign rd_idx = frame_start ? '0 : {tile_y_q, tile_x_q};
    assign px_col = frame_start ? '0 : col_q;
    assign px_row = frame_start ? '0 : row_q;

`ifdef TILE_GRID_EN
    assign px_code = ((px_col == '0) || (px_row == '0)) ? '1 : shadow_code;
`else
    assign px_code = shadow_code;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tile_valid_q <= 1'b0;
            tile_code_q  <= '0;
            sub_x_q      <= '0;
            sub_y_q      <= '0;
            err_overrun  <= 1'b0;
        end else begin
            tile_valid_q <= pix_valid;
            if (pix_valid) begin
                tile_code_q <= px_code;
                sub_x_q     <= px_col;
                sub_y_q     <= px_row;
            end
            if (pix_valid && snap_busy) begin
                err_overrun <= 1'b1;
            end
        end
    end

    assign tile_bus.tile_valid = tile_valid_q;
    assign tile_bus.tile_code  = tile_code_q;
    assign tile_bus.sub_x      = sub_x_q;
    assign tile_bus.sub_y      = sub_y_q;
endmodule

// File: tb/tb_puzzle_tile_reader.sv
// tb/tb_puzzle_tile_reader.sv - directed bench for puzzle_tile_reader with a 1-cycle RAM model
module tb_puzzle_tile_reader;
    import puzzle_pkg::*;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic frame_start = 1'b0;
    logic line_start = 1'b0;
    logic pix_valid = 1'b0;
    logic snap_busy;
    logic err_overrun;

    puzzle_tile_reader_if bus ();

    puzzle_tile_reader u_dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .line_start  (line_start),
        .pix_valid   (pix_valid),
        .snap_busy   (snap_busy),
        .err_overrun (err_overrun),
        .tile_bus    (bus)
    );

    always #5 clock = ~clock;

    logic [4:0] ram [64];
    logic [4:0] ram_rdata_q = '0;
    int         rd_log [$];
    logic [4:0] exp_shadow [64];

    assign bus.ram_rdata = ram_rdata_q;

    always @(posedge clock) begin
        if (bus.ram_re === 1'b1) begin
            rd_log.push_back(int'(bus.ram_raddr));
            ram_rdata_q <= ram[bus.ram_raddr];
        end
    end

    int checks = 0;
    int failures = 0;
    int bad_px = 0;
    int frame_no = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [4:0] exp_code(input int x, input int y);
        int ty;
        ty = y / 30;
        if (ty > 7) ty = 7;
`ifdef TILE_GRID_EN
        if ((x % 32 == 0) || (y % 30 == 0)) return 5'h1F;
`endif
        return exp_shadow[ty * 8 + x / 32];
    endfunction

    task automatic frame_pulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        rd_log.delete();
    endtask

    task automatic snap_observe(input string tag);
        int busy;
        int bad;
        busy = 0;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            if (snap_busy === 1'b1) busy++;
            else if (busy > 0) break;
            tick();
        end
        check({tag, "_busy_cycles"}, busy, 65);
        check({tag, "_num_reads"}, rd_log.size(), 64);
        foreach (rd_log[i]) if (rd_log[i] != i) bad++;
        check({tag, "_read_order"}, bad, 0);
        check({tag, "_re_off"}, bus.ram_re, 0);
        bad = 0;
        for (int i = 0; i < 64; i++) if (u_dut.u_shadow.mem[i] !== ram[i]) bad++;
        check({tag, "_shadow"}, bad, 0);
        for (int i = 0; i < 64; i++) exp_shadow[i] = ram[i];
    endtask

    task automatic pix_line(input int y);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        for (int x = 0; x < 256; x++) begin
            pix_valid = 1'b1;
            tick();
            if (bus.tile_valid !== 1'b1 || bus.tile_code !== exp_code(x, y) ||
                bus.sub_x !== 5'(x % 32) || bus.sub_y !== 5'(y % 30)) bad_px++;
            if (frame_no == 1 && x == 40 && y == 65) begin
                check("t2_valid", bus.tile_valid, 1);
                check("t2_code", bus.tile_code, 17);
                check("t2_sub_x", bus.sub_x, 8);
                check("t2_sub_y", bus.sub_y, 5);
            end
            if (frame_no == 1 && x == 32 && y == 31) begin
`ifdef TILE_GRID_EN
                check("t6_grid_code", bus.tile_code, 31);
`else
                check("t6_plain_code", bus.tile_code, 9);
`endif
            end
            if (frame_no == 1 && x == 40 && y == 40) check("t3_old_code", bus.tile_code, 9);
            if (frame_no == 2 && x == 40 && y == 31) check("t3_new_code", bus.tile_code, 3);
        end
        pix_valid = 1'b0;
        tick();
        if (bus.tile_valid !== 1'b0) bad_px++;
    endtask

    task automatic run_frame(input int nlines);
        bad_px = 0;
        for (int y = 0; y < nlines; y++) begin
            if (frame_no == 1 && y == 35) ram[9] = 5'h03;
            pix_line(y);
        end
        check($sformatf("frame%0d_pixels_bad", frame_no), bad_px, 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int bad;
        for (int i = 0; i < 64; i++) ram[i] = 5'(i % 32);
        for (int i = 0; i < 64; i++) exp_shadow[i] = '0;

        // reset state
        repeat (3) tick();
        check("rst_ram_re", bus.ram_re, 0);
        check("rst_snap_busy", snap_busy, 0);
        check("rst_tile_valid", bus.tile_valid, 0);
        check("rst_err_overrun", err_overrun, 0);
        check("rst_tile_code", bus.tile_code, 0);
        reset_n = 1'b1;
        tick();

        // 1: snapshot after the first frame_start
        frame_pulse();
        check("t1_re_cycle0", bus.ram_re, 1);
        snap_observe("t1");

        // 2, 3, 6: full frame; RAM word 9 changes on line 35
        frame_no = 1;
        run_frame(240);

        // 3: next frame picks up the new code
        frame_pulse();
        snap_observe("t3_snap");
        frame_no = 2;
        run_frame(41);
        frame_no = 3;

        // 4: pixel during snapshot cycle 10, then reset mid-snapshot
        frame_pulse();
        repeat (10) tick();
        pix_valid = 1'b1;
        tick();
        pix_valid = 1'b0;
        check("t4_valid", bus.tile_valid, 1);
        check("t4_err", err_overrun, 1);
        check("t4_code", bus.tile_code, exp_code(0, 0));
        check("t4_sub_x", bus.sub_x, 0);
        repeat (5) tick();
        check("t4_err_held", err_overrun, 1);
        check("t4_busy_mid", snap_busy, 1);
        reset_n = 1'b0;
        #1;
        check("t4_err_cleared", err_overrun, 0);
        check("t4_busy_aborted", snap_busy, 0);
        check("t4_re_aborted", bus.ram_re, 0);
        bad = 0;
        for (int i = 0; i < 64; i++) if (u_dut.u_shadow.mem[i] !== 5'd0) bad++;
        check("t4_shadow_zero", bad, 0);
        tick();
        reset_n = 1'b1;
        tick();

        // 5: frame_start again at snapshot cycle 30 restarts from address 0
        frame_pulse();
        repeat (30) tick();
        check("t5_raddr_before", bus.ram_raddr, 30);
        frame_pulse();
        check("t5_raddr_restart", bus.ram_raddr, 0);
        check("t5_re_restart", bus.ram_re, 1);
        snap_observe("t5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
